// File: rtl/adder421_share_arb.sv
// adder421_share_arb
//   Shares one external pipelined 4:1 adder among NREQ requesters. A
//   round-robin arbiter picks one requester per cycle, forwards its operands
//   to the adder and records its ID in a tag pipe that matches the adder
//   latency. Returning sums, tagged with the ID, go into a result FIFO.
//   The adder cannot stall, so every issue first reserves a FIFO slot
//   (credit). Sums therefore always have a slot waiting when they return.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   req_valid/req_ready  per-requester operand handshake (NREQ bits each)
//   req_a..req_d         packed operands, requester i at [i*IN_WIDTH +: IN_WIDTH]
//   add_in_valid, add_a..add_d   issue to the adder
//   add_s, add_out_valid         sum returning from the adder
//   res_valid/res_ready  result handshake, res_data = sum, res_id = requester
//   err                  sticky flag: tag/valid mismatch or overflowing push
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. req_ready is one-hot or zero and depends on req_valid. A
// requester must not make req_valid depend on req_ready. res_valid does not
// depend on res_ready.

module adder421_share_arb #(
  parameter int NREQ       = 4,
  parameter int IN_WIDTH   = 256,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*IN_WIDTH-1:0] req_a,
  input  logic [NREQ*IN_WIDTH-1:0] req_b,
  input  logic [NREQ*IN_WIDTH-1:0] req_c,
  input  logic [NREQ*IN_WIDTH-1:0] req_d,
  output logic                     add_in_valid,
  output logic [IN_WIDTH-1:0]      add_a,
  output logic [IN_WIDTH-1:0]      add_b,
  output logic [IN_WIDTH-1:0]      add_c,
  output logic [IN_WIDTH-1:0]      add_d,
  input  logic [IN_WIDTH+1:0]      add_s,
  input  logic                     add_out_valid,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IN_WIDTH+1:0]      res_data,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic                     err
);

  localparam int IDW = $clog2(NREQ);
  localparam int SW  = IN_WIDTH + 2;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // ---------------------------------------------------------------- state
  logic [IDW-1:0] ptr;        // last granted requester
  logic [CW-1:0]  reserved;   // in-flight tags + FIFO entries
  logic [LAT-1:0] tag_v;
  logic [IDW-1:0] tag_id [LAT];
  logic [SW-1:0]  mem_data [FIFO_DEPTH];
  logic [IDW-1:0] mem_id [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  // ---------------------------------------------------------------- arbiter
  logic           found;
  logic [IDW-1:0] winner;
  logic           credit_ok;
  logic           issue;

  // The scan starts one past the last winner and wraps, so the most recent
  // winner has the lowest priority in the next cycle.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // The credit check uses the registered count, so a slot freed by a pop is
  // only seen in the next cycle.
  assign credit_ok = (reserved < CW'(FIFO_DEPTH));
  assign issue     = found & credit_ok;
  assign req_ready = issue ? (NREQ'(1) << winner) : '0;

  // No operand register here. The adder's own input registers form the stage.
  assign add_in_valid = issue;
  assign add_a = issue ? req_a[winner*IN_WIDTH +: IN_WIDTH] : '0;
  assign add_b = issue ? req_b[winner*IN_WIDTH +: IN_WIDTH] : '0;
  assign add_c = issue ? req_c[winner*IN_WIDTH +: IN_WIDTH] : '0;
  assign add_d = issue ? req_d[winner*IN_WIDTH +: IN_WIDTH] : '0;

  // ---------------------------------------------------------------- return path
  logic tail_v;
  logic match;
  logic mismatch;
  logic lost;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign tail_v   = tag_v[LAT-1];
  assign match    = tail_v & add_out_valid;
  assign mismatch = tail_v ^ add_out_valid;
  // The adder dropped a sum the tag expected. Its credit is released.
  assign lost     = tail_v & ~add_out_valid;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign res_valid = (count != '0);
  assign pop       = res_valid & res_ready;
  // A pop in the same cycle makes room even when full.
  assign push      = match & (~full | pop);
  // Credit rules out this case. If it happens anyway, flag it and drop the
  // sum so the FIFO stays consistent.
  assign drop      = match & full & ~pop;

  assign res_data = mem_data[rd_ptr];
  assign res_id   = mem_id[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr      <= IDW'(NREQ - 1);
      reserved <= '0;
      err      <= 1'b0;
      tag_v    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) ptr <= winner;

      reserved <= reserved + CW'(issue) - CW'(pop) - CW'(lost) - CW'(drop);

      if (mismatch || drop) err <= 1'b1;

      tag_v[0] <= issue;
      for (int i = 1; i < LAT; i++) tag_v[i] <= tag_v[i-1];

      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset. The valid bits and the count cover it.
  always_ff @(posedge clk) begin
    tag_id[0] <= winner;
    for (int i = 1; i < LAT; i++) tag_id[i] <= tag_id[i-1];
    if (push) begin
      mem_data[wr_ptr] <= add_s;
      mem_id[wr_ptr]   <= tag_id[LAT-1];
    end
  end

endmodule

// File: tb/tb_adder421_share_arb.sv
module tb_adder421_share_arb;

  localparam int NREQ       = 4;
  localparam int W          = 256;
  localparam int LAT        = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int IDW        = 2;
  localparam int SW         = W + 2;
  localparam int EW         = IDW + SW;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic resetn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- dut signals
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*W-1:0] req_c;
  logic [NREQ*W-1:0] req_d;
  logic              add_in_valid;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W-1:0]      add_c;
  logic [W-1:0]      add_d;
  logic [SW-1:0]     add_s;
  logic              add_out_valid;
  logic              res_valid;
  logic              res_ready;
  logic [SW-1:0]     res_data;
  logic [IDW-1:0]    res_id;
  logic              err;
  logic              force_ov;

  adder421_share_arb #(
    .NREQ(NREQ), .IN_WIDTH(W), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .add_in_valid(add_in_valid),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_d(add_d),
    .add_s(add_s), .add_out_valid(add_out_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id),
    .err(err)
  );

  // ---------------------------------------------------------------- adder model
  // Fixed-latency 4:1 adder. It shares resetn with the DUT.
  logic [LAT-1:0] m_v;
  logic [SW-1:0]  m_s [LAT];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_v <= '0;
    end else begin
      m_v[0] <= add_in_valid;
      for (int i = 1; i < LAT; i++) m_v[i] <= m_v[i-1];
    end
    m_s[0] <= SW'(add_a) + SW'(add_b) + SW'(add_c) + SW'(add_d);
    for (int i = 1; i < LAT; i++) m_s[i] <= m_s[i-1];
  end

  assign add_out_valid = m_v[LAT-1] | force_ov;
  assign add_s         = m_s[LAT-1];

  // ---------------------------------------------------------------- scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
    req_d[i*W +: W] = d;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    force_ov  = 1'b0;
    tick();
    resetn = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input string tag, input int bound);
    res_ready = 1'b1;
    for (int n = 0; n < bound && exp_q.size() > 0; n++) begin
      #1;
      if (res_valid) chk(tag, {res_id, res_data}, exp_q.pop_front());
      tick();
    end
    chk({tag, "_left"}, EW'(exp_q.size()), EW'(0));
    #1;
    chk({tag, "_empty"}, EW'(res_valid), EW'(0));
  endtask

  // ---------------------------------------------------------------- timeout
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- directed steps
  logic [W-1:0]    ones;
  logic [NREQ-1:0] sparse_grant [3];

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    force_ov  = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    ones = '1;
    sparse_grant[0] = 4'b0010;
    sparse_grant[1] = 4'b1000;
    sparse_grant[2] = 4'b0010;
    tick();
    tick();
    resetn = 1'b1;
    #1;

    // Reset state
    chk("rst_res_valid", EW'(res_valid), EW'(0));
    chk("rst_add_in_valid", EW'(add_in_valid), EW'(0));
    chk("rst_req_ready", EW'(req_ready), EW'(0));
    chk("rst_err", EW'(err), EW'(0));
    chk("rst_reserved", EW'(dut.reserved), EW'(0));

    // Single request: 1+2+3+4 = 10 after LAT+1 cycles
    set_ops(0, 1, 2, 3, 4);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", EW'(req_ready), EW'(4'b0001));
    chk("single_in_valid", EW'(add_in_valid), EW'(1));
    chk("single_add_a", EW'(add_a), EW'(1));
    tick();
    req_valid = '0;
    for (int n = 1; n <= LAT + 1; n++) begin
      chk("single_latency", EW'(res_valid), EW'(n == LAT + 1));
      if (n < LAT + 1) tick();
    end
    chk("single_result", {res_id, res_data}, {2'd0, 258'd10});
    chk("single_err", EW'(err), EW'(0));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("single_popped", EW'(res_valid), EW'(0));

    // Fairness: requester i adds (i+1)+10+100+1000 = 1111+i
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i, W'(i + 1), 10, 100, 1000);
    for (int k = 0; k < 14; k++) begin
      req_valid = (k < 8) ? 4'hf : 4'h0;
      #1;
      if (k < 8) begin
        chk("fair_grant", EW'(req_ready), EW'(4'b0001 << (k % 4)));
        exp_q.push_back({IDW'(k % 4), SW'(1111 + k % 4)});
      end
      chk("fair_res_valid", EW'(res_valid), EW'(k >= 5 && k < 13));
      if (k >= 5 && k < 13) chk("fair_result", {res_id, res_data}, exp_q.pop_front());
      tick();
    end

    // Backpressure: 8 credits, then stall until the first pop
    do_reset();
    for (int k = 0; k < 14; k++) begin
      set_ops(0, W'(k + 1), 0, 0, 0);
      req_valid = 4'b0001;
      #1;
      chk("bp_ready", EW'(req_ready[0]), EW'(k < 8));
      if (k < 8) exp_q.push_back({2'd0, SW'(k + 1)});
      tick();
    end
    res_ready = 1'b1;
    set_ops(0, 100, 0, 0, 0);
    #1;
    chk("bp_no_reuse", EW'(req_ready[0]), EW'(0));
    chk("bp_full_valid", EW'(res_valid), EW'(1));
    chk("bp_first", {res_id, res_data}, exp_q.pop_front());
    tick();
    #1;
    chk("bp_resume", EW'(req_ready[0]), EW'(1));
    exp_q.push_back({2'd0, 258'd100});
    chk("bp_second", {res_id, res_data}, exp_q.pop_front());
    tick();
    req_valid = '0;
    drain("bp_drain", 30);

    // Sparse wrap: req1 and req3 only, pointer starts at 3
    do_reset();
    res_ready = 1'b1;
    set_ops(1, ones, ones, ones, ones);
    set_ops(3, 5, 6, 7, 8);
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sparse_grant", EW'(req_ready), EW'(sparse_grant[k]));
      tick();
    end
    req_valid = '0;
    exp_q.push_back({2'd1, {{W{1'b1}}, 2'b00}});
    exp_q.push_back({2'd3, 258'd26});
    exp_q.push_back({2'd1, {{W{1'b1}}, 2'b00}});
    drain("sparse_drain", 20);

    // Reset mid-flight discards everything in flight
    do_reset();
    set_ops(0, 1, 1, 1, 1);
    req_valid = 4'b0001;
    #1;
    chk("mid_ready", EW'(req_ready), EW'(4'b0001));
    tick();
    tick();
    tick();
    req_valid = '0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("mid_res_valid", EW'(res_valid), EW'(0));
    chk("mid_reserved", EW'(dut.reserved), EW'(0));
    chk("mid_err", EW'(err), EW'(0));
    set_ops(2, 7, 8, 9, 10);
    req_valid = 4'b0100;
    #1;
    chk("mid_grant", EW'(req_ready), EW'(4'b0100));
    tick();
    req_valid = '0;
    for (int n = 1; n <= LAT + 1; n++) begin
      chk("mid_latency", EW'(res_valid), EW'(n == LAT + 1));
      if (n < LAT + 1) tick();
    end
    chk("mid_result", {res_id, res_data}, {2'd2, 258'd34});

    // Error injection: out_valid with an empty tag pipe
    do_reset();
    #1;
    chk("inj_err_before", EW'(err), EW'(0));
    force_ov = 1'b1;
    tick();
    force_ov = 1'b0;
    #1;
    chk("inj_err_set", EW'(err), EW'(1));
    chk("inj_no_push", EW'(res_valid), EW'(0));
    tick();
    chk("inj_err_sticky", EW'(err), EW'(1));
    chk("inj_no_push2", EW'(res_valid), EW'(0));
    chk("inj_reserved", EW'(dut.reserved), EW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
